// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_24100005_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // One transaction at a time: accept -> issue to memory -> wait for response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_24100005_arb_sel.sv
// Combinational grant selection between IFU and LSU.
// YSYX_24100005_ARB_RR_EN: ties resolve round-robin against the last grant;
// otherwise LSU always wins a tie.
module ysyx_24100005_arb_sel
  import ysyx_24100005_mem_pkg::*;
(
  input  logic en,
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef YSYX_24100005_ARB_RR_EN
  input  logic last_gnt,
`endif
  output logic gnt_ifu,
  output logic gnt_lsu
);

  // At most one grant, and only while the arbiter can take a request.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (en) begin
      if (ifu_valid && lsu_valid) begin
`ifdef YSYX_24100005_ARB_RR_EN
        if (last_gnt == OWN_LSU) gnt_ifu = 1'b1;
        else                     gnt_lsu = 1'b1;
`else
        gnt_lsu = 1'b1;
`endif
      end else begin
        gnt_ifu = ifu_valid;
        gnt_lsu = lsu_valid;
      end
    end
  end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Two-requester (IFU, LSU) single-outstanding memory arbiter.
// YSYX_24100005_ARB_RR_EN selects round-robin tie-breaking (default: LSU first).
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t              state, state_nxt;
  owner_t              owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                accept;
  logic                resp_fire;

`ifdef YSYX_24100005_ARB_RR_EN
  owner_t last_gnt;
`endif

  // Readies are held low while reset is asserted, even in IDLE.
  ysyx_24100005_arb_sel u_sel (
    .en       (state == IDLE && !rst),
    .ifu_valid(ifu_req_valid),
    .lsu_valid(lsu_req_valid),
`ifdef YSYX_24100005_ARB_RR_EN
    .last_gnt (last_gnt),
`endif
    .gnt_ifu  (ifu_req_ready),
    .gnt_lsu  (lsu_req_ready)
  );

  assign accept = ifu_req_ready | lsu_req_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: responses outside WAIT are never consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (mem_resp_valid) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Capture the winner's payload; fetches carry no write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (lsu_req_ready) begin
      owner   <= OWN_LSU;
      addr_q  <= lsu_addr;
      wen_q   <= lsu_wen;
      wdata_q <= lsu_wdata;
      wmask_q <= lsu_wmask;
    end else if (ifu_req_ready) begin
      owner   <= OWN_IFU;
      addr_q  <= ifu_addr;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end
  end

`ifdef YSYX_24100005_ARB_RR_EN
  // Remember who won last so the other side wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= OWN_LSU;
    else if (accept) last_gnt <= lsu_req_ready ? OWN_LSU : OWN_IFU;
  end
`endif

  assign mem_req_valid = (state == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Route the response to the owner only; stores return zero data.
  assign resp_fire      = (state == WAIT) && mem_resp_valid;
  assign ifu_resp_valid = resp_fire && (owner == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && !wen_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_ysyx_24100005_mem_arbiter;

`ifdef YSYX_24100005_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam bit FIRST_LSU = !RR;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    next();
    next();
    rst = 0;
  endtask

  bit          busy, issued, cur_lsu, cur_wen, last_lsu, ipend, lpend;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wmask;
  bit          exp_gi, exp_gl, exp_mv, exp_rv;
  logic [31:0] exp_ird, exp_lrd;

  initial begin
    rst = 1;
    idle_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1;
    sample();
    `CHK("rst_ifu_ready", ifu_req_ready, 0);
    `CHK("rst_lsu_ready", lsu_req_ready, 0);
    `CHK("rst_mem_valid", mem_req_valid, 0);
    `CHK("rst_ifu_resp", ifu_resp_valid, 0);
    `CHK("rst_lsu_resp", lsu_resp_valid, 0);
    `CHK("rst_mem_addr", mem_addr, 0);
    `CHK("rst_mem_wen", mem_wen, 0);
    `CHK("rst_mem_wdata", mem_wdata, 0);
    `CHK("rst_mem_wmask", mem_wmask, 0);
    next();
    idle_inputs();
    next();
    rst = 0;

    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0013;
    sample();
    `CHK("ifu1_ready", ifu_req_ready, 1);
    `CHK("ifu1_lsu_ready", lsu_req_ready, 0);
    `CHK("ifu1_idle_resp", ifu_resp_valid, 0);
    next();
    ifu_req_valid = 0;
    sample();
    `CHK("ifu1_mem_valid", mem_req_valid, 1);
    `CHK("ifu1_mem_addr", mem_addr, 32'h8000_0000);
    `CHK("ifu1_mem_wen", mem_wen, 0);
    `CHK("ifu1_mem_wmask", mem_wmask, 0);
    `CHK("ifu1_issue_resp", ifu_resp_valid, 0);
    next();
    sample();
    `CHK("ifu1_resp", ifu_resp_valid, 1);
    `CHK("ifu1_rdata", ifu_rdata, 32'h13);
    `CHK("ifu1_lsu_resp", lsu_resp_valid, 0);
    `CHK("ifu1_lsu_rdata", lsu_rdata, 0);
    `CHK("ifu1_wait_memv", mem_req_valid, 0);
    next();
    sample();
    `CHK("ifu1_after_resp", ifu_resp_valid, 0);
    `CHK("ifu1_after_memv", mem_req_valid, 0);
    idle_inputs();

    do_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_A5A5;
    sample();
    `CHK("tie1_ifu_ready", ifu_req_ready, !FIRST_LSU);
    `CHK("tie1_lsu_ready", lsu_req_ready, FIRST_LSU);
    next();
    if (FIRST_LSU) lsu_req_valid = 0; else ifu_req_valid = 0;
    sample();
    `CHK("tie1_addr", mem_addr, FIRST_LSU ? 32'h8000_1000 : 32'h8000_0004);
    `CHK("tie1_busy_ifu_ready", ifu_req_ready, 0);
    `CHK("tie1_busy_lsu_ready", lsu_req_ready, 0);
    next();
    sample();
    `CHK("tie1_ifu_resp", ifu_resp_valid, !FIRST_LSU);
    `CHK("tie1_lsu_resp", lsu_resp_valid, FIRST_LSU);
    next();
    sample();
    `CHK("tie2_ifu_ready", ifu_req_ready, FIRST_LSU);
    `CHK("tie2_lsu_ready", lsu_req_ready, !FIRST_LSU);
    next();
    ifu_req_valid = 0; lsu_req_valid = 0;
    sample();
    `CHK("tie2_addr", mem_addr, FIRST_LSU ? 32'h8000_0004 : 32'h8000_1000);
    next();
    sample();
    `CHK("tie2_ifu_resp", ifu_resp_valid, FIRST_LSU);
    `CHK("tie2_lsu_resp", lsu_resp_valid, !FIRST_LSU);
    next();
    idle_inputs();

    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    sample();
    `CHK("st_ready", lsu_req_ready, 1);
    next();
    lsu_req_valid = 0; lsu_addr = 32'h1111_1111; lsu_wen = 0;
    lsu_wdata = 32'h2222_2222; lsu_wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      sample();
      `CHK("st_mem_valid", mem_req_valid, 1);
      `CHK("st_mem_addr", mem_addr, 32'h8000_2000);
      `CHK("st_mem_wen", mem_wen, 1);
      `CHK("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      `CHK("st_mem_wmask", mem_wmask, 4'hF);
      next();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    sample();
    `CHK("st_resp", lsu_resp_valid, 1);
    `CHK("st_rdata", lsu_rdata, 0);
    `CHK("st_ifu_resp", ifu_resp_valid, 0);
    next();
    idle_inputs();

    ifu_req_valid = 1; ifu_addr = 32'h8000_0010; mem_req_ready = 1;
    sample();
    `CHK("dly_accept", ifu_req_ready, 1);
    next();
    ifu_addr = 32'h8000_0014;
    sample();
    `CHK("dly_issue_ready", ifu_req_ready, 0);
    next();
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      `CHK("dly_wait_ready", ifu_req_ready, 0);
      `CHK("dly_wait_resp", ifu_resp_valid, 0);
      next();
    end
    mem_resp_valid = 1; mem_rdata = 32'h0000_0055;
    sample();
    `CHK("dly_resp", ifu_resp_valid, 1);
    `CHK("dly_rdata", ifu_rdata, 32'h55);
    `CHK("dly_resp_ready", ifu_req_ready, 0);
    next();
    mem_resp_valid = 0;
    sample();
    `CHK("dly_reaccept", ifu_req_ready, 1);
    next();
    do_reset();

    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; mem_req_ready = 1;
    sample();
    `CHK("rw_accept", lsu_req_ready, 1);
    next();
    lsu_req_valid = 0;
    next();
    mem_req_ready = 0;
    sample();
    `CHK("rw_in_wait", mem_req_valid, 0);
    next();
    #1 rst = 1;
    #1 rst = 0;
    next();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0077;
    sample();
    `CHK("rw_lsu_resp", lsu_resp_valid, 0);
    `CHK("rw_lsu_rdata", lsu_rdata, 0);
    `CHK("rw_ifu_resp", ifu_resp_valid, 0);
    `CHK("rw_mem_valid", mem_req_valid, 0);
    next();
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
    sample();
    `CHK("rw_idle_ready", ifu_req_ready, 1);
    next();
    do_reset();

    mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      sample();
      `CHK("sp_ifu_resp", ifu_resp_valid, 0);
      `CHK("sp_lsu_resp", lsu_resp_valid, 0);
      `CHK("sp_ifu_rdata", ifu_rdata, 0);
      `CHK("sp_lsu_rdata", lsu_rdata, 0);
      `CHK("sp_mem_valid", mem_req_valid, 0);
      next();
    end
    mem_resp_valid = 0; lsu_req_valid = 1; lsu_addr = 32'h8000_4000;
    sample();
    `CHK("sp_still_idle", lsu_req_ready, 1);
    next();
    lsu_req_valid = 0;
    sample();
    `CHK("sp_issue_addr", mem_addr, 32'h8000_4000);
    next();
    do_reset();

    busy = 0; issued = 0; last_lsu = 1; ipend = 0; lpend = 0;
    cur_lsu = 0; cur_wen = 0; cur_addr = 0; cur_wdata = 0; cur_wmask = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; ifu_addr = $urandom;
      end
      if (!lpend && $urandom_range(0, 2) == 0) begin
        lpend = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      ifu_req_valid  = ipend;
      lsu_req_valid  = lpend;
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_rdata      = $urandom;
      sample();

      exp_gi = 0; exp_gl = 0;
      if (!busy) begin
        if (ipend && lpend) exp_gl = RR ? !last_lsu : 1'b1;
        else                exp_gl = lpend;
        exp_gi = ipend && !exp_gl;
      end
      exp_mv = busy && !issued;
      exp_rv = busy && issued && mem_resp_valid;
      exp_ird = (exp_rv && !cur_lsu) ? mem_rdata : 32'h0;
      exp_lrd = (exp_rv && cur_lsu && !cur_wen) ? mem_rdata : 32'h0;

      n_cmp++;
      if (ifu_req_ready !== exp_gi) begin
        n_err++; $error("FAIL rnd_ifu_ready: observed %0h expected %0h", ifu_req_ready, exp_gi);
      end
      n_cmp++;
      if (lsu_req_ready !== exp_gl) begin
        n_err++; $error("FAIL rnd_lsu_ready: observed %0h expected %0h", lsu_req_ready, exp_gl);
      end
      n_cmp++;
      if (mem_req_valid !== exp_mv) begin
        n_err++; $error("FAIL rnd_mem_valid: observed %0h expected %0h", mem_req_valid, exp_mv);
      end
      if (exp_mv) begin
        `CHK("rnd_mem_addr", mem_addr, cur_addr);
        `CHK("rnd_mem_wen", mem_wen, cur_wen);
        `CHK("rnd_mem_wdata", mem_wdata, cur_wdata);
        `CHK("rnd_mem_wmask", mem_wmask, cur_wmask);
      end
      n_cmp++;
      if (ifu_resp_valid !== (exp_rv && !cur_lsu)) begin
        n_err++; $error("FAIL rnd_ifu_resp: observed %0h", ifu_resp_valid);
      end
      n_cmp++;
      if (lsu_resp_valid !== (exp_rv && cur_lsu)) begin
        n_err++; $error("FAIL rnd_lsu_resp: observed %0h", lsu_resp_valid);
      end
      n_cmp++;
      if (ifu_rdata !== exp_ird) begin
        n_err++; $error("FAIL rnd_ifu_rdata: observed %0h expected %0h", ifu_rdata, exp_ird);
      end
      n_cmp++;
      if (lsu_rdata !== exp_lrd) begin
        n_err++; $error("FAIL rnd_lsu_rdata: observed %0h expected %0h", lsu_rdata, exp_lrd);
      end

      if (exp_rv) busy = 0;
      else if (exp_mv && mem_req_ready) issued = 1;
      else if (exp_gi || exp_gl) begin
        busy = 1; issued = 0; cur_lsu = exp_gl; last_lsu = exp_gl;
        cur_addr  = exp_gl ? lsu_addr : ifu_addr;
        cur_wen   = exp_gl ? lsu_wen : 1'b0;
        cur_wdata = exp_gl ? lsu_wdata : 32'h0;
        cur_wmask = exp_gl ? lsu_wmask : 4'h0;
        if (exp_gl) lpend = 0; else ipend = 0;
      end
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
